bf_feistel_engine: RTL
======================

# bf_feistel_engine

Parametrised, single-clock Blowfish/bcrypt Feistel engine that owns the P-array and drives an external four-bank S-box read port. It executes three operations: full block encryption, key/salt XOR into the P-array, and encryption with write-back of the result into a P-array pair. A valid/ready command stream feeds it and a valid/ready result stream drains it. It sits between the bcrypt sequencer (which drives the command stream) and the S-box SRAM banks, and replaces the multi-clock Feistel datapath.

## Interface
- ROUNDS, 16, Feistel round count; even, 2..16; P-array holds ROUNDS+2 words.
- SBOX_LAT, 1, fixed S-box read latency in cycles, >=1.
- PIW, $clog2((ROUNDS+2)/2), width of P-pair index.
- clk  in  1  sole clock, rising edge.
- reset_l  in  1  asynchronous active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid&&in_ready at rising edge.
- in_cmd  in  2  0=ENC, 1=ENC_P, 2=KEYXOR, 3=PRESET.
- in_l, in_r  in  32 each  plaintext halves; KEYXOR uses in_l only.
- in_pidx  in  PIW  ENC_P destination pair.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  result consumer ready.
- out_l, out_r  out  32 each  ciphertext halves.
- sb_rd  out  1  S-box read strobe.
- sb_a0..sb_a3  out  8 each  bank addresses.
- sb_d0..sb_d3  in  32 each  bank data, valid exactly SBOX_LAT cycles after the sb_rd cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- Reset values:
  - in_ready=1, out_valid=0, out_l=out_r=0, sb_rd=0, sb_a*=0, busy=0.
  - key_idx=0.
  - P[i] = standard Blowfish P init words 0..ROUNDS+1 (243f6a88, 85a308d3, ... 8979fb1b for ROUNDS=16).
- States: IDLE, ISSUE, WAIT (present only when SBOX_LAT>1; holds SBOX_LAT-1 cycles), COMBINE, FINAL, OUT.
- ENC / ENC_P accepted in IDLE:
  - Latch L=in_l, R=in_r, round counter i=0, cmd, pidx.
  - Transition to ISSUE.
- ISSUE:
  - xL = L ^ P[i], registered.
  - sb_rd=1 for this cycle.
  - sb_a0=xL[31:24], sb_a1=xL[23:16], sb_a2=xL[15:8], sb_a3=xL[7:0].
- COMBINE:
  - F = ((sb_d0 + sb_d1) ^ sb_d2) + sb_d3, all mod 2^32.
  - L <= R ^ F; R <= xL; i <= i+1.
  - Next state is ISSUE if i < ROUNDS-1, else FINAL.
- FINAL:
  - out_l <= R ^ P[ROUNDS+1]; out_r <= L ^ P[ROUNDS]; out_valid <= 1.
  - For ENC_P with pidx < (ROUNDS+2)/2: P[2*pidx] <= the value loaded into out_l, P[2*pidx+1] <= the value loaded into out_r, in the same edge.
  - ENC_P with an out-of-range pidx: no P write; output is still produced.
  - Transition to OUT.
- OUT: hold out_* stable. On out_valid&&out_ready: out_valid <= 0, go to IDLE.
- KEYXOR, accepted in IDLE:
  - P[key_idx] ^= in_l.
  - key_idx wraps ROUNDS+1 -> 0.
  - Single cycle; stays in IDLE; in_ready stays 1, so back-to-back KEYXOR runs at one per cycle.
- PRESET, accepted in IDLE: all P restored to init words, key_idx=0. Single cycle.
- in_ready = 1 only in IDLE. Commands are never queued.
- P-array reads during a run see any ENC_P write from a previous command. There is no intra-command forwarding.
- Async reset at any point, including mid-round or in OUT:
  - Immediately forces all reset values and aborts the operation.
  - S-box data returning after reset is ignored.

## Timing
- ENC/ENC_P latency: out_valid rises ROUNDS*(SBOX_LAT+1)+1 cycles after the accepting edge. This is 33 for the defaults and 49 for SBOX_LAT=2.
- One sb_rd pulse per round; exactly ROUNDS pulses per encryption, spaced SBOX_LAT+1 cycles apart.
- Earliest next command acceptance is the edge after the out_valid&&out_ready handshake. If out_ready is held high, the interval between successive accepting edges is ROUNDS*(SBOX_LAT+1)+3.
- KEYXOR/PRESET take effect at the accepting edge and are visible to a command accepted in the next cycle.
- out_ready held low: out_* stable indefinitely, in_ready=0, sb_rd=0.

## Test plan
- Reset, S-box model returns 0, ENC(0,0):
  - out_valid exactly 33 cycles after acceptance.
  - out_l = XOR of P1,P3,...,P17 and out_r = XOR of P0,P2,...,P16, using the init words.
  - 16 sb_rd pulses observed.
- Eighteen back-to-back KEYXOR words equal to the P init words zero the P-array (key_idx wraps to 0). With the S-box at 0, ENC(0x01234567,0x89abcdef) gives out_l=0x89abcdef, out_r=0x01234567.
- F arithmetic: with P zeroed, S-box model returns d0=0xffffffff, d1=1, d2=0, d3=5 for every read, and F=5 each round. ENC(0,0) with ROUNDS=2 gives out_l=5, out_r=5.
- ENC_P: with P zeroed and the S-box at 0, ENC_P(pidx=0, 0xa,0xb) outputs (0xb,0xa) and sets P0=0xb, P1=0xa. A following ENC(0,0) then issues sb_a3=0x0b in its first ISSUE cycle.
- Back-pressure and latency:
  - Hold out_ready=0 for 10 cycles: outputs stable, in_ready=0.
  - Release: the next command is accepted on the edge after the handshake.
  - Repeat with SBOX_LAT=2: latency 49.
- Reset mid-round (round 7) asserted for 1 cycle: all outputs return to reset values, and PRESET-equivalent P is restored. A subsequent ENC(0,0) matches scenario 1.

Source files
------------

// File: rtl/bf_feistel_engine.sv
// Blowfish Feistel engine: owns the P-array and drives a 4-bank S-box port.
// Runs ENC, ENC with P-pair write-back, KEYXOR and PRESET commands.
module bf_feistel_engine #(
    parameter int ROUNDS   = 16,
    parameter int SBOX_LAT = 1,
    parameter int PIW      = $clog2((ROUNDS + 2) / 2)
) (
    input  logic           clk,
    input  logic           reset_l,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_cmd,
    input  logic [31:0]    in_l,
    input  logic [31:0]    in_r,
    input  logic [PIW-1:0] in_pidx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_l,
    output logic [31:0]    out_r,
    output logic           sb_rd,
    output logic [7:0]     sb_a0,
    output logic [7:0]     sb_a1,
    output logic [7:0]     sb_a2,
    output logic [7:0]     sb_a3,
    input  logic [31:0]    sb_d0,
    input  logic [31:0]    sb_d1,
    input  logic [31:0]    sb_d2,
    input  logic [31:0]    sb_d3,
    output logic           busy
);

    localparam int NW = ROUNDS + 2;
    localparam int NP = NW / 2;
    localparam int IW = $clog2(NW);
    localparam int WW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [IW-1:0]  LAST_I = IW'(ROUNDS - 1);
    localparam logic [IW-1:0]  K_LAST = IW'(NW - 1);
    localparam logic [PIW:0]   NP_W   = (PIW + 1)'(NP);
    localparam logic [WW-1:0]  W_LAST = WW'((SBOX_LAT > 1) ? SBOX_LAT - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_COMBINE, S_FINAL, S_OUT
    } state_t;

    function automatic logic [31:0] p_init(input int k);
        case (k)
            0:  return 32'h243f6a88;
            1:  return 32'h85a308d3;
            2:  return 32'h13198a2e;
            3:  return 32'h03707344;
            4:  return 32'ha4093822;
            5:  return 32'h299f31d0;
            6:  return 32'h082efa98;
            7:  return 32'hec4e6c89;
            8:  return 32'h452821e6;
            9:  return 32'h38d01377;
            10: return 32'hbe5466cf;
            11: return 32'h34e90c6c;
            12: return 32'hc0ac29b7;
            13: return 32'hc97c50dd;
            14: return 32'h3f84d5b5;
            15: return 32'hb5470917;
            16: return 32'h9216d5d9;
            17: return 32'h8979fb1b;
            default: return 32'h0;
        endcase
    endfunction

    state_t          r_state;
    logic [31:0]     r_p [NW];
    logic [31:0]     r_l, r_r, r_xl;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_kidx;
    logic            r_enc_p;
    logic [PIW-1:0]  r_pidx;
    logic [WW-1:0]   r_wcnt;
    logic [31:0]     r_out_l, r_out_r;
    logic            r_out_valid;
    logic            r_sb_rd;

    logic [31:0]     w_f, w_l_next, w_pnext, w_fin_l, w_fin_r;
    logic            w_pok;
    logic [IW-1:0]   w_pw;

    assign w_f      = ((sb_d0 + sb_d1) ^ sb_d2) + sb_d3;
    assign w_l_next = r_r ^ w_f;
    assign w_pnext  = r_p[r_i + IW'(1)];
    assign w_fin_l  = r_r ^ r_p[NW-1];
    assign w_fin_r  = r_l ^ r_p[NW-2];
    assign w_pok    = {1'b0, r_pidx} < NP_W;
    assign w_pw     = IW'({r_pidx, 1'b0});

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_l     = r_out_l;
    assign out_r     = r_out_r;
    assign sb_rd     = r_sb_rd;
    assign sb_a0     = r_xl[31:24];
    assign sb_a1     = r_xl[23:16];
    assign sb_a2     = r_xl[15:8];
    assign sb_a3     = r_xl[7:0];

    // xL is computed one edge early so the S-box address is a clean register
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state     <= S_IDLE;
            r_l         <= '0;
            r_r         <= '0;
            r_xl        <= '0;
            r_i         <= '0;
            r_kidx      <= '0;
            r_enc_p     <= 1'b0;
            r_pidx      <= '0;
            r_wcnt      <= '0;
            r_out_l     <= '0;
            r_out_r     <= '0;
            r_out_valid <= 1'b0;
            r_sb_rd     <= 1'b0;
            for (int k = 0; k < NW; k++) r_p[k] <= p_init(k);
        end else begin
            r_sb_rd <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (in_cmd)
                            2'd0, 2'd1: begin
                                r_l     <= in_l;
                                r_r     <= in_r;
                                r_i     <= '0;
                                r_enc_p <= in_cmd[0];
                                r_pidx  <= in_pidx;
                                r_xl    <= in_l ^ r_p[0];
                                r_sb_rd <= 1'b1;
                                r_state <= S_ISSUE;
                            end
                            2'd2: begin
                                r_p[r_kidx] <= r_p[r_kidx] ^ in_l;
                                r_kidx <= (r_kidx == K_LAST) ? '0 : r_kidx + IW'(1);
                            end
                            default: begin
                                for (int k = 0; k < NW; k++) r_p[k] <= p_init(k);
                                r_kidx <= '0;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    r_wcnt  <= '0;
                    r_state <= (SBOX_LAT > 1) ? S_WAIT : S_COMBINE;
                end
                S_WAIT: begin
                    if (r_wcnt == W_LAST) r_state <= S_COMBINE;
                    else r_wcnt <= r_wcnt + WW'(1);
                end
                S_COMBINE: begin
                    r_l <= w_l_next;
                    r_r <= r_xl;
                    r_i <= r_i + IW'(1);
                    if (r_i < LAST_I) begin
                        r_xl    <= w_l_next ^ w_pnext;
                        r_sb_rd <= 1'b1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_out_l     <= w_fin_l;
                    r_out_r     <= w_fin_r;
                    r_out_valid <= 1'b1;
                    if (r_enc_p && w_pok) begin
                        r_p[w_pw]         <= w_fin_l;
                        r_p[w_pw + IW'(1)] <= w_fin_r;
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
